// File: rtl/spi_slave_regif.sv
// spi_slave_regif
//   SPI mode-0 slave that bridges an external SPI master onto the register map.
//   SCLK/CS_N/MOSI are oversampled in the clk domain. A frame is a command byte
//   {rnw, addr} followed by one or more DATA_W-bit words, MSB first. The address
//   auto-increments for each word, so a frame can carry a burst of writes or reads.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   sclk, cs_n, mosi  SPI pins from the master (asynchronous to clk)
//   miso, miso_oe     SPI return data and its output enable (read data phase only)
//   wr_en/addr/data   1-cycle write strobe with address and data to the regmap
//   rd_en/addr        1-cycle read request to the regmap
//   rd_data           regmap read data, valid exactly 1 clk after rd_en
//   frame_err         1-cycle pulse when CS_N rises with a partial byte or word
//   busy              high while a frame is being processed
module spi_slave_regif #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int CMD_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        WR_DATA,
        RD_LOAD,
        RD_DATA
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. Chains clear to 0 so that a reset taken while
    // CS_N is low keeps reading "selected" until the master really lets go.
    // ------------------------------------------------------------------
    logic [2:0] pin_async;
    logic [2:0] pin_sync;

    assign pin_async = {sclk, cs_n, mosi};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic [SYNC_STG-1:0] chain_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                chain_reg <= '0;
            end else begin
                chain_reg <= {chain_reg[SYNC_STG-2:0], pin_async[gi]};
            end
        end
        assign pin_sync[gi] = chain_reg[SYNC_STG-1];
    end

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_d_reg, cs_n_d_reg;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s = pin_sync[2];
    assign cs_n_s = pin_sync[1];
    assign mosi_s = pin_sync[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d_reg <= 1'b0;
            cs_n_d_reg <= 1'b0;
        end else begin
            sclk_d_reg <= sclk_s;
            cs_n_d_reg <= cs_n_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d_reg;
    assign sclk_fall = ~sclk_s & sclk_d_reg;
    assign cs_fall   = ~cs_n_s & cs_n_d_reg;
    assign cs_rise   = cs_n_s & ~cs_n_d_reg;

    // ------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------
    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0]  rx_reg, rx_next;
    logic [DATA_W-1:0]  tx_reg, tx_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic               sampled_reg, sampled_next;
    logic               miso_reg, miso_next;
    logic               miso_oe_reg, miso_oe_next;
    logic               wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]  wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0]  wr_data_reg, wr_data_next;
    logic               rd_en_reg, rd_en_next;
    logic [ADDR_W-1:0]  rd_addr_reg, rd_addr_next;
    logic               frame_err_reg, frame_err_next;
    logic [DATA_W-1:0]  rx_shift;

    assign rx_shift = {rx_reg[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= WAIT_CS;
            bit_cnt_reg   <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            addr_reg      <= '0;
            sampled_reg   <= 1'b0;
            miso_reg      <= 1'b0;
            miso_oe_reg   <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            addr_reg      <= addr_next;
            sampled_reg   <= sampled_next;
            miso_reg      <= miso_next;
            miso_oe_reg   <= miso_oe_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            rd_en_reg     <= rd_en_next;
            rd_addr_reg   <= rd_addr_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        addr_next      = addr_reg;
        sampled_next   = sampled_reg;
        miso_next      = miso_reg;
        miso_oe_next   = miso_oe_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        rd_en_next     = 1'b0;
        rd_addr_next   = rd_addr_reg;
        frame_err_next = 1'b0;

        case (state_reg)
            WAIT_CS: begin
                if (cs_n_s) state_next = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_next   = CMD;
                    bit_cnt_next = '0;
                    rx_next      = '0;
                end
            end
            CMD: begin
                if (sclk_rise) begin
                    rx_next = rx_shift;
                    if (bit_cnt_reg == CNT_W'(CMD_W - 1)) begin
                        bit_cnt_next = '0;
                        addr_next    = rx_shift[ADDR_W-1:0];
                        if (rx_shift[CMD_W-1]) begin
                            rd_en_next   = 1'b1;
                            rd_addr_next = rx_shift[ADDR_W-1:0];
                            state_next   = RD_LOAD;
                        end else begin
                            state_next = WR_DATA;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            WR_DATA: begin
                if (sclk_rise) begin
                    rx_next = rx_shift;
                    if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_next = '0;
                        wr_en_next   = 1'b1;
                        wr_addr_next = addr_reg;
                        wr_data_next = rx_shift;
                        addr_next    = addr_reg + ADDR_W'(1);
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            RD_LOAD: begin
                // First cycle here is the rd_en cycle; rd_data is valid on the next.
                if (!rd_en_reg) begin
                    tx_next      = rd_data;
                    miso_next    = rd_data[DATA_W-1];
                    miso_oe_next = 1'b1;
                    bit_cnt_next = '0;
                    sampled_next = 1'b0;
                    state_next   = RD_DATA;
                end
            end
            RD_DATA: begin
                // A fall only advances MISO after the master has sampled the
                // current bit on a rise; this skips the trailing fall of the
                // command byte, which arrives after the MSB is already driven.
                if (sclk_rise) begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    sampled_next = 1'b1;
                end else if (sclk_fall && sampled_reg) begin
                    sampled_next = 1'b0;
                    if (bit_cnt_reg == CNT_W'(DATA_W)) begin
                        addr_next    = addr_reg + ADDR_W'(1);
                        rd_en_next   = 1'b1;
                        rd_addr_next = addr_reg + ADDR_W'(1);
                        state_next   = RD_LOAD;
                    end else begin
                        tx_next   = {tx_reg[DATA_W-2:0], 1'b0};
                        miso_next = tx_reg[DATA_W-2];
                    end
                end
            end
            default: state_next = WAIT_CS;
        endcase

        // Deselect ends the frame from any state; a partial unit is dropped.
        if (cs_rise) begin
            if ((state_reg == CMD || state_reg == WR_DATA || state_reg == RD_DATA) &&
                bit_cnt_reg != '0) begin
                frame_err_next = 1'b1;
            end
            state_next   = IDLE;
            bit_cnt_next = '0;
            sampled_next = 1'b0;
            miso_next    = 1'b0;
            miso_oe_next = 1'b0;
            wr_en_next   = 1'b0;
            rd_en_next   = 1'b0;
        end
    end

    assign miso      = miso_reg;
    assign miso_oe   = miso_oe_reg;
    assign wr_en     = wr_en_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign rd_en     = rd_en_reg;
    assign rd_addr   = rd_addr_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE) && (state_reg != WAIT_CS);

endmodule
